// File: rtl/rv32i_types_pkg.sv
// Shared RV32I type definitions: memory access widths and data-memory FSM states.
package rv32i_types_pkg;

    // Encodings 5-7 are unused and reported as access errors by the data memory.
    typedef enum logic [2:0] {
        WT_BYTE               = 3'd0,
        WT_HALF_WORD          = 3'd1,
        WT_WORD               = 3'd2,
        WT_BYTE_UNSIGNED      = 3'd3,
        WT_HALF_WORD_UNSIGNED = 3'd4
    } width_type_enum;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_enum;

endpackage

// File: rtl/rv32i_mem_lane_align.sv
// Combinational lane logic: store byte enables and replication, load lane select
// with extension, and alignment / width-encoding error detection.
module rv32i_mem_lane_align
    import rv32i_types_pkg::*;
(
    input  width_type_enum width_i,
    input  logic [1:0]     addr_lo_i,
    input  logic [31:0]    wdata_i,
    input  logic [31:0]    rword_i,
    output logic [3:0]     be_o,
    output logic [31:0]    wdata_o,
    output logic [31:0]    rdata_o,
    output logic           err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rword_i[7:0];
            2'd1:    byte_sel = rword_i[15:8];
            2'd2:    byte_sel = rword_i[23:16];
            default: byte_sel = rword_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        err_o   = 1'b0;
        case (width_i)
            WT_BYTE, WT_BYTE_UNSIGNED: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = (width_i == WT_BYTE) ? {{24{byte_sel[7]}}, byte_sel}
                                               : {24'h0, byte_sel};
            end
            WT_HALF_WORD, WT_HALF_WORD_UNSIGNED: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = (width_i == WT_HALF_WORD) ? {{16{half_sel[15]}}, half_sel}
                                                    : {16'h0, half_sel};
                err_o   = addr_lo_i[0];
            end
            WT_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rword_i;
                err_o   = |addr_lo_i;
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_data_memory.sv
// Word-organised data RAM responding to one load/store at a time over valid/ready,
// with a programmable response latency and error flagging instead of corruption.
module rv32i_data_memory
    import rv32i_types_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic [31:0]    req_addr,
    input  logic [31:0]    req_wdata,
    input  width_type_enum req_width,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [31:0]    rsp_rdata,
    output logic           rsp_error
);

    localparam int unsigned    IDX_W     = $clog2(DEPTH_WORDS);
    localparam int unsigned    CNT_W     = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam logic [29:0]    DEPTH_LIM = 30'(DEPTH_WORDS);

    dmem_state_enum   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    width_type_enum   width_q, width_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_error_q, rsp_error_d;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             accept;
    logic             commit;
    logic             cur_write;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    width_type_enum   cur_width;
    logic [IDX_W-1:0] word_idx;
    logic             range_err;
    logic             align_err;
    logic             access_err;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;
    logic [31:0]      rdata_ext;
    logic             mem_we;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

    // With LATENCY 1 the commit edge is the acceptance edge, so use the live request there.
    assign cur_write = (state_q == IDLE) ? req_write : write_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign cur_width = (state_q == IDLE) ? req_width : width_q;

    assign word_idx   = cur_addr[IDX_W+1:2];
    assign range_err  = (cur_addr[31:2] >= DEPTH_LIM);
    assign access_err = range_err || align_err;
    assign mem_we     = commit && cur_write && !access_err && !rst;

    rv32i_mem_lane_align u_align (
        .width_i   (cur_width),
        .addr_lo_i (cur_addr[1:0]),
        .wdata_i   (cur_wdata),
        .rword_i   (mem_q[word_idx]),
        .be_o      (be),
        .wdata_o   (wdata_rep),
        .rdata_o   (rdata_ext),
        .err_o     (align_err)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        width_d     = width_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    width_d = req_width;
                    if (LATENCY == 1) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rsp_error_d = access_err;
            rsp_rdata_d = (access_err || cur_write) ? 32'h0 : rdata_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    always_ff @(posedge clk) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        width_q <= width_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

endmodule
